pipeline_stall_sequencer: RTL and testbench
===========================================

# pipeline_stall_sequencer

Central stall/flush scheduler for the 5-stage MIPS pipeline. It arbitrates between four stall sources: memory wait, taken control transfer, HI/LO dependency on the iterative multiply/divide unit, and load-use. Each cycle it drives one consistent set of PC, IF/ID and downstream pipeline-register enables, flushes and bubbles. It owns the mult/div busy counter and a saturating stall-cycle counter, and sits between the hazard detection logic, the branch/jump resolution logic and the pipeline registers.

## Interface
- MULDIV_LATENCY, 32: cycles the mult/div unit stays busy after an accepted start; legal range 1..255.
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_wait_i  input  1  data/instruction memory not ready; whole pipeline must hold.
- redirect_i  input  1  taken branch, jump or jump-register resolved in ID.
- load_use_i  input  1  load in ID/EX writes a register read by the ID instruction.
- hilo_use_i  input  1  ID instruction is MFHI/MFLO/MULT/MULTU/DIV/DIVU.
- muldiv_start_i  input  1  mult/div instruction leaving ID/EX into EX this cycle.
- pc_en_o  output  1  PC write enable.
- ifid_en_o  output  1  IF/ID register write enable.
- ifid_flush_o  output  1  load NOP into IF/ID.
- idex_bubble_o  output  1  zero control fields entering ID/EX.
- pipe_en_o  output  1  enable for ID/EX, EX/MEM and MEM/WB registers.
- muldiv_busy_o  output  1  mult/div counter nonzero.
- muldiv_done_o  output  1  final busy cycle (counter == 1).
- overrun_o  output  1  sticky: start received while busy.
- state_o  output  2  registered class of previous cycle: 0 RUN, 1 FREEZE, 2 MDWAIT, 3 LDSTALL.
- stall_cycles_o  output  16  count of cycles with pc_en_o=0, saturating.

## Operation
- Control outputs are combinational from inputs and md_cnt. Priority, highest first:
  1. mem_wait_i=1 (FREEZE): pc_en, ifid_en, pipe_en = 0; flush = 0; bubble = 0. Redirect and load-use are ignored this cycle and act when the wait clears.
  2. redirect_i=1 (RUN class): pc_en, ifid_en, pipe_en = 1; ifid_flush = 1; idex_bubble = 1.
  3. md_cnt≠0 and hilo_use_i=1 (MDWAIT): pc_en, ifid_en = 0; idex_bubble = 1; pipe_en = 1; flush = 0.
  4. load_use_i=1 (LDSTALL): same outputs as MDWAIT.
  5. Otherwise (RUN): pc_en, ifid_en, pipe_en = 1; flush, bubble = 0.
- state_o registers the class selected each cycle. Redirect and normal flow both count as RUN.
- md_cnt is 8 bits.
  - Loaded with MULDIV_LATENCY when muldiv_start_i=1, pipe_en_o=1 and md_cnt=0.
  - Otherwise decrements by 1 when nonzero. It keeps decrementing during FREEZE.
  - muldiv_start_i while md_cnt≠0: ignored, counter unchanged, overrun_o set. overrun_o clears only on reset.
  - muldiv_start_i with pipe_en_o=0: ignored, no overrun.
- stall_cycles_o increments when pc_en_o=0, including FREEZE, MDWAIT and LDSTALL. It holds at 16'hFFFF.
- Reset asserted (reset=0):
  - md_cnt=0, stall_cycles_o=0, overrun_o=0, state_o=0.
  - pc_en, ifid_en and pipe_en are forced to 0; flush and bubble are forced to 0.
  - Reset mid-busy abandons the mult/div count with no done pulse.

## Timing
- Enables, flush and bubble take effect in the same cycle as the causing inputs (zero latency).
- Accepted start at edge N: muldiv_busy_o is high for cycles N+1 .. N+MULDIV_LATENCY. muldiv_done_o is high only in cycle N+MULDIV_LATENCY.
- The first cycle after the last busy cycle has md_cnt=0. A pending hilo_use_i proceeds in that cycle without stall.
- state_o and stall_cycles_o lag the decision by one cycle.
- Simultaneous redirect + load_use: redirect wins, no stall. The load-use instruction is flushed.
- Simultaneous mem_wait + anything: freeze only. Counter still decrements.
- Reset deassertion: first edge after reset=1 starts normal operation, with state RUN.

## Test plan
- Reset with all inputs low, then release → pc_en/ifid_en/pipe_en go 1, state_o=0, stall_cycles_o=0.
- load_use_i pulsed one cycle → pc_en=0, ifid_en=0, idex_bubble=1 that cycle; next cycle state_o=3; stall_cycles_o=1.
- MULDIV_LATENCY=4, muldiv_start_i at edge 0, hilo_use_i held high from cycle 1 → MDWAIT in cycles 1–4, muldiv_done_o in cycle 4, RUN in cycle 5, stall_cycles_o=4.
- redirect_i and load_use_i high together → ifid_flush=1, idex_bubble=1, pc_en=1, no stall increment.
- mem_wait_i held 3 cycles during busy count with MULDIV_LATENCY=5 → all enables 0 for 3 cycles, busy still ends 5 cycles after start.
- muldiv_start_i again while busy → overrun_o=1, stays 1 until reset; counter unaffected. Then force 70000 load-use cycles → stall_cycles_o=16'hFFFF.

Source files
------------

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Each cycle it picks one stall class (FREEZE > redirect > MDWAIT > LDSTALL > RUN)
// and drives a consistent set of PC, IF/ID and downstream register controls.
// It also owns the mult/div busy counter and a saturating stall-cycle counter.
// There is no valid/ready handshake here: all control outputs are level signals
// that the pipeline registers act on in the same cycle they are asserted.
module pipeline_stall_sequencer #(
  parameter int unsigned MULDIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_wait_i,
  input  logic        redirect_i,
  input  logic        load_use_i,
  input  logic        hilo_use_i,
  input  logic        muldiv_start_i,
  output logic        pc_en_o,
  output logic        ifid_en_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        pipe_en_o,
  output logic        muldiv_busy_o,
  output logic        muldiv_done_o,
  output logic        overrun_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FREEZE  = 2'd1,
    ST_MDWAIT  = 2'd2,
    ST_LDSTALL = 2'd3
  } stall_class_e;

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_LATENCY);

  stall_class_e class_d, state_q;
  logic [7:0]   md_cnt_d, md_cnt_q;
  logic         overrun_d, overrun_q;
  logic [15:0]  stall_d, stall_q;
  logic         md_busy;

  assign md_busy = (md_cnt_q != 8'd0);

  // Prioritised per-cycle control decision; everything is held off while reset is low.
  always_comb begin
    class_d       = ST_RUN;
    pc_en_o       = 1'b0;
    ifid_en_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_en_o     = 1'b0;
    if (!reset) begin
      class_d = ST_RUN;
    end else if (mem_wait_i) begin
      // Whole pipeline holds; redirect/load-use are re-evaluated once the wait clears.
      class_d = ST_FREEZE;
    end else if (redirect_i) begin
      // Flushing IF/ID and bubbling ID/EX also discards any load-use victim in ID.
      class_d       = ST_RUN;
      pc_en_o       = 1'b1;
      ifid_en_o     = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      pipe_en_o     = 1'b1;
    end else if (md_busy && hilo_use_i) begin
      class_d       = ST_MDWAIT;
      idex_bubble_o = 1'b1;
      pipe_en_o     = 1'b1;
    end else if (load_use_i) begin
      class_d       = ST_LDSTALL;
      idex_bubble_o = 1'b1;
      pipe_en_o     = 1'b1;
    end else begin
      class_d   = ST_RUN;
      pc_en_o   = 1'b1;
      ifid_en_o = 1'b1;
      pipe_en_o = 1'b1;
    end
  end

  // Next values for the mult/div counter, overrun flag and stall-cycle counter.
  always_comb begin
    md_cnt_d  = md_cnt_q;
    overrun_d = overrun_q;
    stall_d   = stall_q;
    // A start only counts when the mult/div instruction actually advances into EX.
    if (muldiv_start_i && pipe_en_o && !md_busy) begin
      md_cnt_d = MD_LOAD;
    end else if (md_busy) begin
      // Keeps counting through FREEZE: the unit itself is not stalled by memory.
      md_cnt_d = md_cnt_q - 8'd1;
    end
    if (muldiv_start_i && pipe_en_o && md_busy) begin
      overrun_d = 1'b1;
    end
    if (!pc_en_o && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers; reset abandons any in-flight mult/div count without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      md_cnt_q  <= 8'd0;
      overrun_q <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      state_q   <= class_d;
      md_cnt_q  <= md_cnt_d;
      overrun_q <= overrun_d;
      stall_q   <= stall_d;
    end
  end

  assign muldiv_busy_o  = md_busy;
  assign muldiv_done_o  = (md_cnt_q == 8'd1);
  assign overrun_o      = overrun_q;
  assign state_o        = state_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer. Two instances share the inputs:
// dut uses a mult/div latency of 4, dut5 a latency of 5.
module tb_pipeline_stall_sequencer;

  localparam logic [4:0] C_OFF   = 5'b00000; // {pc_en, ifid_en, flush, bubble, pipe_en}
  localparam logic [4:0] C_RUN   = 5'b11001;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_STALL = 5'b00011;

  // clock / reset block
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic mem_wait = 1'b0, redirect = 1'b0, load_use = 1'b0, hilo_use = 1'b0, muldiv_start = 1'b0;

  logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, busy, done, overrun;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        pc_en5, ifid_en5, ifid_flush5, idex_bubble5, pipe_en5, busy5, done5, overrun5;
  logic [1:0]  state5;
  logic [15:0] stall_cycles5;
  logic [4:0]  ctrl, ctrl5;

  assign ctrl  = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en};
  assign ctrl5 = {pc_en5, ifid_en5, ifid_flush5, idex_bubble5, pipe_en5};

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  pipeline_stall_sequencer #(.MULDIV_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .mem_wait_i(mem_wait), .redirect_i(redirect),
    .load_use_i(load_use), .hilo_use_i(hilo_use), .muldiv_start_i(muldiv_start),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .pipe_en_o(pipe_en), .muldiv_busy_o(busy),
    .muldiv_done_o(done), .overrun_o(overrun), .state_o(state),
    .stall_cycles_o(stall_cycles)
  );

  pipeline_stall_sequencer #(.MULDIV_LATENCY(5)) dut5 (
    .clk(clk), .reset(reset), .mem_wait_i(mem_wait), .redirect_i(redirect),
    .load_use_i(load_use), .hilo_use_i(hilo_use), .muldiv_start_i(muldiv_start),
    .pc_en_o(pc_en5), .ifid_en_o(ifid_en5), .ifid_flush_o(ifid_flush5),
    .idex_bubble_o(idex_bubble5), .pipe_en_o(pipe_en5), .muldiv_busy_o(busy5),
    .muldiv_done_o(done5), .overrun_o(overrun5), .state_o(state5),
    .stall_cycles_o(stall_cycles5)
  );

  // driver: advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    redirect = 1'b1; load_use = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ctrl !== C_OFF) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_OFF); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    checks++; if ({busy, done, overrun} !== 3'b000) begin errors++; $display("FAIL reset_md: got %b expected 000", {busy, done, overrun}); end
    redirect = 1'b0; load_use = 1'b0; reset = 1'b1;
    #3;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL release_ctrl: got %b expected %b", ctrl, C_RUN); end
    step(); #3;
    checks++; if (state !== 2'd0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL release_regs: got state %0d stall %0d expected 0 0", state, stall_cycles); end
  endtask

  task automatic test_load_use();
    step(); load_use = 1'b1; #3;
    checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL ldstall_ctrl: got %b expected %b", ctrl, C_STALL); end
    step(); load_use = 1'b0; #3;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL ldstall_state: got %0d expected 3", state); end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL ldstall_count: got %0d expected 1", stall_cycles); end
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL ldstall_resume: got %b expected %b", ctrl, C_RUN); end
  endtask

  task automatic test_muldiv_wait();
    logic [1:0] exp_bd;
    step(); muldiv_start = 1'b1; #3;
    checks++; if (busy !== 1'b0 || ctrl !== C_RUN) begin errors++; $display("FAIL md_start: got busy %b ctrl %b expected 0 %b", busy, ctrl, C_RUN); end
    step(); muldiv_start = 1'b0; hilo_use = 1'b1;
    exp_q.push_back(2'b10); exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    exp_q.push_back(2'b11); exp_q.push_back(2'b00);
    for (int c = 1; c <= 5; c++) begin
      #3;
      exp_bd = exp_q.pop_front();
      checks++; if ({busy, done} !== exp_bd) begin errors++; $display("FAIL md_busy_done c%0d: got %b expected %b", c, {busy, done}, exp_bd); end
      checks++; if (ctrl !== ((c <= 4) ? C_STALL : C_RUN)) begin errors++; $display("FAIL md_ctrl c%0d: got %b expected %b", c, ctrl, (c <= 4) ? C_STALL : C_RUN); end
      checks++; if (state !== ((c == 1) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL md_state c%0d: got %0d expected %0d", c, state, (c == 1) ? 0 : 2); end
      step();
    end
    hilo_use = 1'b0; #3;
    checks++; if (state !== 2'd0 || stall_cycles !== 16'd5) begin errors++; $display("FAIL md_after: got state %0d stall %0d expected 0 5", state, stall_cycles); end
  endtask

  task automatic test_redirect_load_use();
    step(); redirect = 1'b1; load_use = 1'b1; #3;
    checks++; if (ctrl !== C_REDIR) begin errors++; $display("FAIL redir_ctrl: got %b expected %b", ctrl, C_REDIR); end
    step(); redirect = 1'b0; load_use = 1'b0; #3;
    checks++; if (state !== 2'd0 || stall_cycles !== 16'd5) begin errors++; $display("FAIL redir_regs: got state %0d stall %0d expected 0 5", state, stall_cycles); end
  endtask

  task automatic test_mem_wait_during_busy();
    step(); muldiv_start = 1'b1;
    step(); muldiv_start = 1'b0; mem_wait = 1'b1; redirect = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #3;
      checks++; if (ctrl5 !== C_OFF || busy5 !== 1'b1) begin errors++; $display("FAIL freeze c%0d: got ctrl %b busy %b expected %b 1", c, ctrl5, busy5, C_OFF); end
      step();
    end
    mem_wait = 1'b0; redirect = 1'b0; #3;
    checks++; if (ctrl5 !== C_RUN || {busy5, done5} !== 2'b10) begin errors++; $display("FAIL freeze_end: got ctrl %b busy/done %b expected %b 10", ctrl5, {busy5, done5}, C_RUN); end
    checks++; if (state5 !== 2'd1) begin errors++; $display("FAIL freeze_state: got %0d expected 1", state5); end
    checks++; if (done !== 1'b1 || stall_cycles !== 16'd8) begin errors++; $display("FAIL freeze_lat4: got done %b stall %0d expected 1 8", done, stall_cycles); end
    step(); #3;
    checks++; if ({busy5, done5} !== 2'b11) begin errors++; $display("FAIL freeze_done5: got %b expected 11", {busy5, done5}); end
    step(); #3;
    checks++; if ({busy5, done5} !== 2'b00) begin errors++; $display("FAIL freeze_idle5: got %b expected 00", {busy5, done5}); end
  endtask

  task automatic test_start_gated();
    step(); mem_wait = 1'b1; muldiv_start = 1'b1; #3;
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL gated_pipe_en: got %b expected 0", pipe_en); end
    step(); mem_wait = 1'b0; muldiv_start = 1'b0; #3;
    checks++; if ({busy, overrun} !== 2'b00) begin errors++; $display("FAIL gated_start: got busy/overrun %b expected 00", {busy, overrun}); end
    checks++; if (state !== 2'd1 || stall_cycles !== 16'd9) begin errors++; $display("FAIL gated_regs: got state %0d stall %0d expected 1 9", state, stall_cycles); end
  endtask

  task automatic test_overrun();
    step(); muldiv_start = 1'b1;
    step(); #3;
    checks++; if (busy !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got busy %b overrun %b expected 1 0", busy, overrun); end
    step(); muldiv_start = 1'b0; #3;
    checks++; if ({busy, done, overrun} !== 3'b101) begin errors++; $display("FAIL ovr_set: got %b expected 101", {busy, done, overrun}); end
    step(); step(); #3;
    checks++; if ({busy, done} !== 2'b11) begin errors++; $display("FAIL ovr_count: got %b expected 11", {busy, done}); end
    step(); #3;
    checks++; if ({busy, overrun} !== 2'b01) begin errors++; $display("FAIL ovr_sticky: got %b expected 01", {busy, overrun}); end
  endtask

  task automatic test_saturate();
    step(); load_use = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    checks++; if (stall_cycles !== 16'd1009) begin errors++; $display("FAIL sat_mid: got %0d expected 1009", stall_cycles); end
    repeat (69000) @(posedge clk);
    #1;
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", stall_cycles); end
    checks++; if (state !== 2'd3 || overrun !== 1'b1) begin errors++; $display("FAIL sat_state: got state %0d overrun %b expected 3 1", state, overrun); end
    load_use = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    step(); muldiv_start = 1'b1;
    step(); muldiv_start = 1'b0; #3;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_pre: got %b expected 1", busy); end
    reset = 1'b0; #1;
    checks++; if ({busy, done, overrun} !== 3'b000 || stall_cycles !== 16'd0 || state !== 2'd0) begin errors++; $display("FAIL rst_async: got md %b stall %0d state %0d expected 000 0 0", {busy, done, overrun}, stall_cycles, state); end
    checks++; if (ctrl !== C_OFF) begin errors++; $display("FAIL rst_ctrl: got %b expected %b", ctrl, C_OFF); end
    step(); step(); reset = 1'b1; #3;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL rst_release: got %b expected %b", ctrl, C_RUN); end
    step(); #3;
    checks++; if ({busy, done} !== 2'b00 || state !== 2'd0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_after: got busy/done %b state %0d stall %0d expected 00 0 0", {busy, done}, state, stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv_wait();
    test_redirect_load_use();
    test_mem_wait_during_busy();
    test_start_gated();
    test_overrun();
    test_saturate();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
